// File: rtl/fetch_unit.sv
// RV32I instruction fetch stage: owns the PC, issues in-order word fetches under a
// credit limit, buffers responses for decode and discards stale responses after a redirect.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic [6:0]  if_opcode
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW:0] DEPTH_W = DEPTH[CW:0];

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [CW-1:0] occ_q, occ_d;
  logic [CW-1:0] out_q, out_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [IW-1:0] head_q, head_d, tail_q, tail_d;
  logic [IW-1:0] pq_head_q, pq_head_d, pq_tail_q, pq_tail_d;

  logic [31:0]   buf_pc_q    [DEPTH];
  logic [31:0]   buf_pc_d    [DEPTH];
  logic [31:0]   buf_instr_q [DEPTH];
  logic [31:0]   buf_instr_d [DEPTH];
  logic [31:0]   pq_q        [DEPTH];
  logic [31:0]   pq_d        [DEPTH];

  logic [CW:0]   credit_used;
  logic          req_fire;
  logic          rsp_take;
  logic          rsp_push;
  logic          rsp_drop;
  logic          pop;

  function automatic logic [IW-1:0] ptr_inc(input logic [IW-1:0] p);
    if (p == IW'(DEPTH - 1)) return '0;
    return p + IW'(1);
  endfunction

  // A same-cycle pop frees its slot, so a 1-cycle memory streams at full rate.
  always_comb begin
    pop            = (occ_q != '0) && if_ready;
    credit_used    = {1'b0, occ_q} + {1'b0, out_q} - {{CW{1'b0}}, pop};
    imem_req_valid = (state_q == RUN) && !redirect_valid && (credit_used < DEPTH_W);
    req_fire       = imem_req_valid && imem_req_ready;
    rsp_take       = imem_rsp_valid && (out_q != '0);
    rsp_drop       = rsp_take && (drop_q != '0);
    rsp_push       = rsp_take && (drop_q == '0) && (state_q == RUN) && !redirect_valid;
  end

  assign imem_req_addr = fetch_pc_q;
  assign if_valid      = (occ_q != '0);
  assign if_pc         = if_valid ? buf_pc_q[head_q] : 32'h0;
  assign if_instr      = if_valid ? buf_instr_q[head_q] : 32'h0;
  assign if_opcode     = if_instr[6:0];

  always_comb begin
    fetch_pc_d  = fetch_pc_q;
    head_d      = head_q;
    tail_d      = tail_q;
    pq_head_d   = pq_head_q;
    pq_tail_d   = pq_tail_q;
    buf_pc_d    = buf_pc_q;
    buf_instr_d = buf_instr_q;
    pq_d        = pq_q;

    if (req_fire) begin
      fetch_pc_d      = fetch_pc_q + 32'd4;
      pq_d[pq_tail_q] = fetch_pc_q;
      pq_tail_d       = ptr_inc(pq_tail_q);
    end
    if (rsp_take) begin
      pq_head_d = ptr_inc(pq_head_q);
    end
    out_d = out_q + CW'(req_fire) - CW'(rsp_take);

    if (rsp_push) begin
      buf_pc_d[tail_q]    = pq_q[pq_head_q];
      buf_instr_d[tail_q] = imem_rsp_data;
      tail_d              = ptr_inc(tail_q);
    end
    if (pop) begin
      head_d = ptr_inc(head_q);
    end
    occ_d  = occ_q + CW'(rsp_push) - CW'(pop);
    drop_d = rsp_drop ? (drop_q - CW'(1)) : drop_q;

    // Everything still in flight after this cycle belongs to the old path.
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc & ~32'd3;
      occ_d      = '0;
      head_d     = '0;
      tail_d     = '0;
      drop_d     = out_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT:    state_d = RUN;
      RUN:     if (redirect_valid && (drop_d != '0)) state_d = FLUSH;
      FLUSH:   if (!redirect_valid && (drop_d == '0)) state_d = RUN;
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= BOOT;
      fetch_pc_q <= RESET_PC;
      occ_q      <= '0;
      out_q      <= '0;
      drop_q     <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      pq_head_q  <= '0;
      pq_tail_q  <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      occ_q      <= occ_d;
      out_q      <= out_d;
      drop_q     <= drop_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      pq_head_q  <= pq_head_d;
      pq_tail_q  <= pq_tail_d;
    end
  end

  // Storage is qualified by the pointers and counters, so it needs no reset.
  always_ff @(posedge clk) begin
    buf_pc_q    <= buf_pc_d;
    buf_instr_q <= buf_instr_d;
    pq_q        <= pq_d;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: in-order memory responder with random latency and a
// queue-based model of the expected instruction stream seen by decode.
`timescale 1ns/1ps
module tb_fetch_unit;

  localparam logic [31:0] RPC   = 32'h0000_0100;
  localparam int          DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic [6:0]  if_opcode;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_pc          (if_pc),
    .if_instr       (if_instr),
    .if_opcode      (if_opcode)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
    logic [31:0] rdata;
    int          due;
    bit          stale;
  } fl_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } be_t;

  fl_t         mq[$];
  be_t         bq[$];
  logic [31:0] acc_log[$];
  logic [31:0] exp_fetch;
  logic [31:0] scramble;
  bit          boot, flush, rsp_is_orphan;
  int          cyc, orphans, lat_min, lat_max;
  int          checks, errors;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return a ^ scramble;
  endfunction

  function automatic bit rsp_pending();
    return (orphans == 0) && (mq.size() > 0) && (mq[0].due <= cyc);
  endfunction

  // First half of a cycle: memory drives its response, outputs settle.
  task automatic half();
    rsp_is_orphan = 1'b0;
    if (rst_n && orphans > 0) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'hDEAD_0013 ^ 32'(orphans);
      rsp_is_orphan  = 1'b1;
    end else if (rst_n && mq.size() > 0 && mq[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mq[0].rdata;
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
    #4;
  endtask

  // Second half: compare outputs with the model, advance the model, cross the edge.
  task automatic tick();
    bit          ev, pp, acc, erv;
    logic [31:0] epc, ein;
    fl_t         e;
    fl_t         t;
    ev  = (bq.size() != 0);
    epc = ev ? bq[0].pc : 32'h0;
    ein = ev ? bq[0].instr : 32'h0;
    pp  = ev && if_ready;
    erv = rst_n && !boot && !flush && !redirect_valid &&
          ((bq.size() - int'(pp) + mq.size()) < DEPTH);

    checks++;
    if (if_valid !== ev) begin
      errors++;
      $display("FAIL if_valid cyc=%0d got=%b exp=%b", cyc, if_valid, ev);
    end
    checks++;
    if (if_pc !== epc) begin
      errors++;
      $display("FAIL if_pc cyc=%0d got=%h exp=%h", cyc, if_pc, epc);
    end
    checks++;
    if (if_instr !== ein) begin
      errors++;
      $display("FAIL if_instr cyc=%0d got=%h exp=%h", cyc, if_instr, ein);
    end
    checks++;
    if (if_opcode !== ein[6:0]) begin
      errors++;
      $display("FAIL if_opcode cyc=%0d got=%h exp=%h", cyc, if_opcode, ein[6:0]);
    end
    checks++;
    if (imem_req_valid !== erv) begin
      errors++;
      $display("FAIL req_valid cyc=%0d got=%b exp=%b", cyc, imem_req_valid, erv);
    end
    checks++;
    if (imem_req_addr !== exp_fetch) begin
      errors++;
      $display("FAIL req_addr cyc=%0d got=%h exp=%h", cyc, imem_req_addr, exp_fetch);
    end

    acc = rst_n && (imem_req_valid === 1'b1) && (imem_req_ready === 1'b1);
    if (rst_n) begin
      if (pp) void'(bq.pop_front());
      if (imem_rsp_valid && !rsp_is_orphan) begin
        e = mq.pop_front();
        if (!e.stale && !redirect_valid) bq.push_back('{pc: e.pc, instr: e.data});
      end
      if (rsp_is_orphan) orphans--;
      if (acc) begin
        mq.push_back('{pc: exp_fetch, data: mem_data(exp_fetch), rdata: mem_data(imem_req_addr),
                       due: cyc + int'($urandom_range(lat_max, lat_min)), stale: redirect_valid});
        acc_log.push_back(imem_req_addr);
        exp_fetch = exp_fetch + 32'd4;
      end
      if (redirect_valid) begin
        for (int i = 0; i < mq.size(); i++) begin
          t = mq[i];
          t.stale = 1'b1;
          mq[i] = t;
        end
        bq.delete();
        exp_fetch = redirect_pc & ~32'd3;
        flush = flush || (mq.size() > 0);
      end else if (flush) begin
        flush = (mq.size() > 0);
      end
      boot = 1'b0;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic cycle();
    half();
    tick();
  endtask

  task automatic wait_two_inflight(input string name);
    int n;
    n = 0;
    while (!(mq.size() == 2 && !flush && !mq[0].stale) && n < 40) begin
      cycle();
      n++;
    end
    checks++;
    if (n >= 40) begin
      errors++;
      $display("FAIL %s_setup inflight got=%0d exp=2", name, mq.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    imem_req_ready = 1'b1; if_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    mq.delete(); bq.delete(); acc_log.delete();
    boot = 1'b1; flush = 1'b0; orphans = 0; exp_fetch = RPC;
    scramble = 32'h0; lat_min = 1; lat_max = 1;
    @(posedge clk); #1;
    cycle();
    half();
    checks++;
    if (imem_req_valid !== 1'b0 || imem_req_addr !== RPC) begin
      errors++;
      $display("FAIL reset_req got=%b/%h exp=0/%h", imem_req_valid, imem_req_addr, RPC);
    end
    checks++;
    if (if_valid !== 1'b0 || if_pc !== 32'h0 || if_instr !== 32'h0 || if_opcode !== 7'h0) begin
      errors++;
      $display("FAIL reset_if got=%b/%h/%h/%h exp=0/0/0/0", if_valid, if_pc, if_instr, if_opcode);
    end
    tick();
  endtask

  task automatic test_boot_stream();
    int k;
    rst_n = 1'b1;
    half();
    checks++;
    if (imem_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL boot_no_req got=%b exp=0", imem_req_valid);
    end
    tick();
    half();
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== RPC) begin
      errors++;
      $display("FAIL first_req got=%b/%h exp=1/%h", imem_req_valid, imem_req_addr, RPC);
    end
    tick();
    k = 0;
    for (int i = 0; i < 8 && k < 3; i++) begin
      half();
      if (k > 0 || if_valid === 1'b1) begin
        checks++;
        if (if_valid !== 1'b1 || if_pc !== RPC + 32'(4 * k) || if_instr !== RPC + 32'(4 * k)) begin
          errors++;
          $display("FAIL stream_%0d got=%b/%h/%h exp=1/%h/%h", k, if_valid, if_pc, if_instr,
                   RPC + 32'(4 * k), RPC + 32'(4 * k));
        end
        k++;
      end
      tick();
    end
    checks++;
    if (k < 3) begin
      errors++;
      $display("FAIL stream_timeout got=%0d exp=3", k);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] held;
    held = 32'h0;
    scramble = $urandom;
    if_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      half();
      if (i == 0) held = (bq.size() != 0) ? bq[0].pc : 32'hFFFF_FFFF;
      checks++;
      if (if_valid !== 1'b1 || if_pc !== held) begin
        errors++;
        $display("FAIL bp_hold_%0d got=%b/%h exp=1/%h", i, if_valid, if_pc, held);
      end
      if (i == 4) begin
        checks++;
        if (imem_req_valid !== 1'b0) begin
          errors++;
          $display("FAIL bp_credit got=%b exp=0", imem_req_valid);
        end
      end
      tick();
    end
    if_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      half();
      checks++;
      if (if_valid !== 1'b1) begin
        errors++;
        $display("FAIL bp_resume_%0d got=%b exp=1", i, if_valid);
      end
      tick();
    end
  endtask

  task automatic test_mem_stall();
    logic [31:0] stall_addr;
    stall_addr = exp_fetch;
    imem_req_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      half();
      checks++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== stall_addr) begin
        errors++;
        $display("FAIL stall_%0d got=%b/%h exp=1/%h", i, imem_req_valid, imem_req_addr, stall_addr);
      end
      tick();
    end
    imem_req_ready = 1'b1;
    repeat (6) cycle();
  endtask

  task automatic test_redirect_flush();
    bit seen;
    lat_min = 3; lat_max = 3;
    wait_two_inflight("redir");
    redirect_valid = 1'b1; redirect_pc = 32'h0000_2002;
    half();
    checks++;
    if (imem_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL redir_no_req got=%b exp=0", imem_req_valid);
    end
    tick();
    redirect_valid = 1'b0;
    acc_log.delete();
    seen = 1'b0;
    for (int i = 0; i < 25; i++) begin
      half();
      if (flush) begin
        checks++;
        if (if_valid !== 1'b0 || imem_req_valid !== 1'b0) begin
          errors++;
          $display("FAIL redir_flush got=%b/%b exp=0/0", if_valid, imem_req_valid);
        end
      end
      if (!seen && if_valid === 1'b1) begin
        seen = 1'b1;
        checks++;
        if (if_pc !== 32'h0000_2000) begin
          errors++;
          $display("FAIL redir_first_pc got=%h exp=00002000", if_pc);
        end
      end
      tick();
    end
    checks++;
    if (acc_log.size() == 0 || acc_log[0] !== 32'h0000_2000 || !seen) begin
      errors++;
      $display("FAIL redir_first_req got=%h seen=%b exp=00002000",
               (acc_log.size() != 0) ? acc_log[0] : 32'hx, seen);
    end
  endtask

  task automatic test_back_to_back();
    bit done, seen;
    wait_two_inflight("b2b");
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0400;
    cycle();
    redirect_valid = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 10 && !done; i++) begin
      if (flush && rsp_pending()) begin
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0801;
        done = 1'b1;
      end
      cycle();
      redirect_valid = 1'b0;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL b2b_setup got=0 exp=1");
    end
    seen = 1'b0;
    for (int i = 0; i < 25; i++) begin
      half();
      if (if_valid === 1'b1) begin
        checks++;
        if (if_pc < 32'h0000_0800 || if_pc >= 32'h0000_0900 || (!seen && if_pc !== 32'h0000_0800)) begin
          errors++;
          $display("FAIL b2b_stream got=%h exp=%s", if_pc, seen ? "0x800..0x8FC" : "00000800");
        end
        seen = 1'b1;
      end
      tick();
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL b2b_timeout got=0 exp=1");
    end
  endtask

  task automatic test_async_reset();
    bit seen;
    lat_min = 3; lat_max = 3;
    wait_two_inflight("arst");
    imem_rsp_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (imem_req_valid !== 1'b0 || imem_req_addr !== RPC) begin
      errors++;
      $display("FAIL arst_req got=%b/%h exp=0/%h", imem_req_valid, imem_req_addr, RPC);
    end
    checks++;
    if (if_valid !== 1'b0 || if_pc !== 32'h0 || if_instr !== 32'h0 || if_opcode !== 7'h0) begin
      errors++;
      $display("FAIL arst_if got=%b/%h/%h/%h exp=0/0/0/0", if_valid, if_pc, if_instr, if_opcode);
    end
    mq.delete(); bq.delete();
    boot = 1'b1; flush = 1'b0; exp_fetch = RPC; orphans = 2;
    @(posedge clk); #1; cyc++;
    cycle();
    rst_n = 1'b1;
    cycle();
    half();
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== RPC || if_valid !== 1'b0) begin
      errors++;
      $display("FAIL arst_restart got=%b/%h/%b exp=1/%h/0", imem_req_valid, imem_req_addr, if_valid, RPC);
    end
    tick();
    seen = 1'b0;
    for (int i = 0; i < 15 && !seen; i++) begin
      half();
      if (if_valid === 1'b1) begin
        seen = 1'b1;
        checks++;
        if (if_pc !== RPC) begin
          errors++;
          $display("FAIL arst_first_pc got=%h exp=%h", if_pc, RPC);
        end
      end
      tick();
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL arst_timeout got=0 exp=1");
    end
  endtask

  task automatic test_random();
    scramble = $urandom;
    lat_min = 1; lat_max = 4;
    for (int i = 0; i < 600; i++) begin
      imem_req_ready = ($urandom_range(3, 0) != 0);
      if_ready       = ($urandom_range(2, 0) != 0);
      redirect_valid = ($urandom_range(24, 0) == 0);
      redirect_pc    = $urandom;
      cycle();
    end
    redirect_valid = 1'b0; imem_req_ready = 1'b1; if_ready = 1'b1;
    repeat (20) cycle();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cyc    = 0;
    test_reset();
    test_boot_stream();
    test_backpressure();
    test_mem_stall();
    test_redirect_flush();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
